// File: rtl/fe_carry_seq.sv
// Carry-propagation stage for GF(2^255-19) elements in 10-limb radix-2^25.5 form.
// One limb carry per cycle. Result 11 cycles after accept. Stalls in DONE while out_ready is low.
module fe_carry_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] f,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] h
);

  typedef enum logic [1:0] {IDLE, CARRY, DONE} state_t;

  state_t             state_q;
  logic [3:0]         k_q;
  logic               out_valid_q;
  logic signed [63:0] r_q [10];
  logic signed [63:0] r_d [10];

  logic [3:0]         idx;
  logic [3:0]         nxt;
  logic signed [63:0] sel;
  logic signed [63:0] c;
  logic signed [63:0] add;
  logic               accept;

  assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;

  // Step k carries limb k; step 10 revisits limb 0 to absorb the x19 wrap.
  always_comb begin
    idx = (k_q == 4'd10) ? 4'd0 : k_q;
    nxt = (idx == 4'd9) ? 4'd0 : idx + 4'd1;
    sel = r_q[idx];
    if (idx[0]) begin
      c = (sel + 64'sd16777216) >>> 25;
    end else begin
      c = (sel + 64'sd33554432) >>> 26;
    end
    add = (idx == 4'd9) ? ((c <<< 4) + (c <<< 1) + c) : c;
    for (int i = 0; i < 10; i++) begin
      r_d[i] = r_q[i];
    end
    r_d[idx] = idx[0] ? (sel - (c <<< 25)) : (sel - (c <<< 26));
    r_d[nxt] = r_q[nxt] + add;
  end

  always_comb begin
    h = '0;
    for (int i = 0; i < 10; i++) begin
      h[32*i +: 32] = r_q[i][31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= 4'd0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < 10; i++) begin
              r_q[i] <= 64'(signed'(f[32*i +: 32]));
            end
            k_q     <= 4'd0;
            state_q <= CARRY;
          end
        end
        CARRY: begin
          for (int i = 0; i < 10; i++) begin
            r_q[i] <= r_d[i];
          end
          if (k_q == 4'd10) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              for (int i = 0; i < 10; i++) begin
                r_q[i] <= 64'(signed'(f[32*i +: 32]));
              end
              k_q     <= 4'd0;
              state_q <= CARRY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fe_carry_seq.sv
// Directed-vector bench for fe_carry_seq: table vectors, congruence/bound checks, stall and reset sequences.
module tb_fe_carry_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] f;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] h;

  int checks = 0;
  int errors = 0;

  fe_carry_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .f(f),
    .out_valid(out_valid), .out_ready(out_ready), .h(h)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [319:0] fv;
    logic [319:0] hv;
  } vec_t;

  logic signed [319:0] p;

  function automatic logic [319:0] limb(input int i, input logic [31:0] v);
    logic [319:0] x;
    x = '0;
    x[32*i +: 32] = v;
    return x;
  endfunction

  function automatic logic signed [319:0] value(input logic [319:0] x);
    int off [10] = '{0, 26, 51, 77, 102, 128, 153, 179, 204, 230};
    logic signed [319:0] acc;
    logic signed [319:0] t;
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      t = {{288{x[32*i+31]}}, x[32*i +: 32]};
      acc = acc + (t <<< off[i]);
    end
    return acc;
  endfunction

  function automatic logic bounds_ok(input logic [319:0] x);
    longint v;
    longint lim;
    bounds_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = longint'($signed(x[32*i +: 32]));
      if (v < 0) v = -v;
      lim = (i % 2 == 0) ? 64'sd33554432 : ((i == 1) ? 64'sd16777217 : 64'sd16777216);
      if (v > lim) bounds_ok = 1'b0;
    end
  endfunction

  task automatic chk(input string nm, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic start_elem(input logic [319:0] fv);
    in_valid = 1'b1;
    f        = fv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic rdy_in_carry);
    lat = 0;
    rdy_in_carry = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!out_valid && in_ready) rdy_in_carry = 1'b1;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t         tbl [12];
  int           lat;
  logic         bad;
  logic [319:0] hold;
  logic [319:0] ha;
  logic [319:0] hb;
  logic [319:0] fv;
  logic [319:0] s;
  logic signed [319:0] d;

  initial begin
    p = (320'sd1 <<< 255) - 320'sd19;
    tbl[0]  = '{"zero",        '0,                                   '0};
    tbl[1]  = '{"l0_pos",      limb(0, 32'h0400_0000),               limb(1, 32'h1)};
    tbl[2]  = '{"l0_neg",      limb(0, 32'hFC00_0000),               limb(1, 32'hFFFF_FFFF)};
    tbl[3]  = '{"top_wrap",    limb(9, 32'h0200_0000),               limb(0, 32'd19)};
    tbl[4]  = '{"l1_half",     limb(1, 32'h0100_0000),               limb(1, 32'hFF00_0000) | limb(2, 32'h1)};
    tbl[5]  = '{"l0_half",     limb(0, 32'h0200_0000),               limb(0, 32'hFE00_0000) | limb(1, 32'h1)};
    tbl[6]  = '{"l0_below",    limb(0, 32'h01FF_FFFF),               limb(0, 32'h01FF_FFFF)};
    tbl[7]  = '{"all_m1",      {10{32'hFFFF_FFFF}},                  {10{32'hFFFF_FFFF}}};
    tbl[8]  = '{"l0_max",      limb(0, 32'h7FFF_FFFF),               limb(0, 32'hFFFF_FFFF) | limb(1, 32'd32)};
    tbl[9]  = '{"l9_max",      limb(9, 32'h7FFF_FFFF),               limb(0, 32'd1216) | limb(9, 32'hFFFF_FFFF)};
    tbl[10] = '{"l8_to_l9",    limb(8, 32'h0400_0000),               limb(9, 32'h1)};
    tbl[11] = '{"ripple",      limb(0, 32'h0400_0000) | limb(1, 32'h00FF_FFFF),
                               limb(1, 32'hFF00_0000) | limb(2, 32'h1)};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; f = '0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 320'(in_ready), 320'(1'b0));
    chk("reset_out_valid", 320'(out_valid), 320'(1'b0));
    chk("reset_h", h, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", 320'(in_ready), 320'(1'b1));

    for (int v = 0; v < 12; v++) begin
      start_elem(tbl[v].fv);
      wait_done(lat, bad);
      chk({tbl[v].name, "_lat"}, 320'(lat), 320'(11));
      chk({tbl[v].name, "_h"}, h, tbl[v].hv);
      if (v == 0) chk("carry_in_ready_low", 320'(bad), 320'(1'b0));
      pop();
    end

    // Random vectors and sums of two carried results: congruence mod p and limb bounds.
    ha = '0;
    for (int n = 0; n < 60; n++) begin
      if (n < 40) begin
        for (int i = 0; i < 10; i++) fv[32*i +: 32] = $urandom();
      end else begin
        for (int i = 0; i < 10; i++) s[32*i +: 32] = ha[32*i +: 32] + hb[32*i +: 32];
        fv = s;
      end
      start_elem(fv);
      wait_done(lat, bad);
      d = (value(fv) - value(h)) % p;
      chk("rand_congruent", 320'(d == 0), 320'(1'b1));
      chk("rand_bounds", 320'(bounds_ok(h)), 320'(1'b1));
      hb = ha;
      ha = h;
      pop();
    end

    // Stall for 20 cycles, then release with a back-to-back accept.
    start_elem(tbl[1].fv);
    wait_done(lat, bad);
    hold = h;
    bad  = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (h !== hold || !out_valid || in_ready) bad = 1'b1;
    end
    chk("stall_stable", 320'(bad), 320'(1'b0));
    chk("stall_h", hold, tbl[1].hv);
    out_ready = 1'b1; in_valid = 1'b1; f = tbl[3].fv;
    #1;
    chk("b2b_in_ready", 320'(in_ready), 320'(1'b1));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("b2b_transferred", 320'(out_valid), 320'(1'b0));
    wait_done(lat, bad);
    chk("b2b_lat", 320'(lat), 320'(11));
    chk("b2b_h", h, tbl[3].hv);
    pop();

    // Reset in the middle of the carry sequence.
    start_elem(tbl[9].fv);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_out_valid", 320'(out_valid), 320'(1'b0));
    chk("midrst_h", h, '0);
    chk("midrst_idle", 320'(in_ready), 320'(1'b1));
    bad = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("midrst_no_emit", 320'(bad), 320'(1'b0));
    start_elem(tbl[2].fv);
    wait_done(lat, bad);
    chk("after_rst_lat", 320'(lat), 320'(11));
    chk("after_rst_h", h, tbl[2].hv);
    pop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
